// File: rtl/fifo_burst_writer.sv
// fifo_burst_writer
// Write-side producer for the dual-clock FIFO, living entirely in the FIFO
// write domain. Words arrive on a valid/ready stream and are staged in a
// small buffer. Once a group is complete (buffer full, packet end, or idle
// timeout) the block waits until the FIFO reports enough free space,
// including a guard margin that covers the lag of the FIFO full/count
// flags. It then writes the group as one back-to-back burst.
//
// Ports:
//   i_arst      async reset, active-high
//   i_wclk      write-domain clock (rising edge)
//   i_valid     input word valid
//   o_ready     block can accept a word this cycle
//   i_data      input word
//   i_last      input word ends a packet (forces a flush)
//   o_we        FIFO write enable (registered)
//   o_wdata     FIFO write data (registered)
//   i_full      FIFO full flag
//   i_wcnt      FIFO write-side fill count (saturates at all-ones)
//   o_pkt_done  pulse on the write carrying a packet's last word
//   o_ovf_err   sticky: i_full seen high during a burst
module fifo_burst_writer #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 8,
  parameter int BURST_LEN     = 4,
  parameter int GUARD         = 4,
  parameter int FLUSH_TIMEOUT = 16
) (
  input  logic                  i_arst,
  input  logic                  i_wclk,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_last,
  output logic                  o_we,
  output logic [DATA_WIDTH-1:0] o_wdata,
  input  logic                  i_full,
  input  logic [ADDR_WIDTH-1:0] i_wcnt,
  output logic                  o_pkt_done,
  output logic                  o_ovf_err
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam int IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int TMR_W = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
  localparam int SPC_W = ADDR_WIDTH + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BURST_LEN);
  localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_END  = TMR_W'((FLUSH_TIMEOUT > 0) ? FLUSH_TIMEOUT - 1 : 0);
  // FIFO capacity is 2**ADDR_WIDTH-1 words; kept one bit wider so the
  // free-space arithmetic never wraps.
  localparam logic [SPC_W-1:0] FIFO_CAP = {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam logic [SPC_W-1:0] GUARD_W  = SPC_W'(GUARD);

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    WAIT_ROOM = 2'd1,
    BURST     = 2'd2
  } state_t;

  state_t                  state_r;
  logic [CNT_W-1:0]        count_r;
  logic [CNT_W-1:0]        idx_r;
  logic [TMR_W-1:0]        timer_r;
  logic                    last_flag_r;
  logic [DATA_WIDTH-1:0]   buf_r [BURST_LEN];

  logic                    accept_s;
  logic [SPC_W-1:0]        free_s;
  logic [SPC_W-1:0]        need_s;
  logic                    room_s;
  logic                    issue_last_s;

  // Ready is gated by reset so nothing is accepted while i_arst is high.
  assign o_ready      = (state_r == FILL) && (count_r < CNT_FULL) && !i_arst;
  assign accept_s     = i_valid && o_ready;
  assign free_s       = FIFO_CAP - {1'b0, i_wcnt};
  assign need_s       = SPC_W'(count_r) + GUARD_W;
  assign room_s       = !i_full && (free_s >= need_s);
  assign issue_last_s = (idx_r == (count_r - CNT_ONE));

  // Staging buffer: accepted words land at the current fill position.
  always_ff @(posedge i_wclk or posedge i_arst) begin
    if (i_arst) begin
      for (int i = 0; i < BURST_LEN; i++) begin
        buf_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (accept_s) begin
      buf_r[count_r[IDX_W-1:0]] <= i_data;
    end else begin
      buf_r <= buf_r;
    end
  end

  // Control FSM with registered write-port outputs.
  always_ff @(posedge i_wclk or posedge i_arst) begin
    if (i_arst) begin
      state_r     <= FILL;
      count_r     <= CNT_ZERO;
      idx_r       <= CNT_ZERO;
      timer_r     <= TMR_ZERO;
      last_flag_r <= 1'b0;
      o_we        <= 1'b0;
      o_wdata     <= {DATA_WIDTH{1'b0}};
      o_pkt_done  <= 1'b0;
      o_ovf_err   <= 1'b0;
    end else begin
      case (state_r)
        FILL: begin
          o_we       <= 1'b0;
          o_pkt_done <= 1'b0;
          if (accept_s) begin
            count_r <= count_r + CNT_ONE;
            timer_r <= TMR_ZERO;
            if (i_last) begin
              last_flag_r <= 1'b1;
            end
            if (i_last || ((count_r + CNT_ONE) == CNT_FULL)) begin
              state_r <= WAIT_ROOM;
            end
          end else if (count_r == CNT_ZERO) begin
            timer_r <= TMR_ZERO;
          end else if ((FLUSH_TIMEOUT != 0) && (timer_r == TMR_END)) begin
            // Idle partial group: flush it rather than hold words forever.
            state_r <= WAIT_ROOM;
          end else begin
            timer_r <= timer_r + TMR_ONE;
          end
        end

        WAIT_ROOM: begin
          o_we       <= 1'b0;
          o_pkt_done <= 1'b0;
          if (room_s) begin
            state_r <= BURST;
          end
        end

        BURST: begin
          if (!i_full) begin
            o_we    <= 1'b1;
            o_wdata <= buf_r[idx_r[IDX_W-1:0]];
            if (issue_last_s) begin
              state_r     <= FILL;
              count_r     <= CNT_ZERO;
              idx_r       <= CNT_ZERO;
              timer_r     <= TMR_ZERO;
              o_pkt_done  <= last_flag_r;
              last_flag_r <= 1'b0;
            end else begin
              idx_r      <= idx_r + CNT_ONE;
              o_pkt_done <= 1'b0;
            end
          end else begin
            // Full mid-burst means the guard margin was violated: pause
            // without advancing and flag it permanently.
            o_we       <= 1'b0;
            o_pkt_done <= 1'b0;
            o_ovf_err  <= 1'b1;
          end
        end

        default: begin
          state_r     <= FILL;
          count_r     <= CNT_ZERO;
          idx_r       <= CNT_ZERO;
          timer_r     <= TMR_ZERO;
          last_flag_r <= 1'b0;
          o_we        <= 1'b0;
          o_pkt_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Self-checking bench for fifo_burst_writer: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// queue-based behavioural model.
module tb_fifo_burst_writer;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int BL = 4;
  localparam int GD = 4;
  localparam int TO = 16;

  logic          arst, clk, valid, ready, last, we, full, pkt, ovf;
  logic [DW-1:0] data, wdata;
  logic [AW-1:0] wcnt;

  fifo_burst_writer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL), .GUARD(GD), .FLUSH_TIMEOUT(TO)
  ) dut (
    .i_arst(arst), .i_wclk(clk), .i_valid(valid), .o_ready(ready), .i_data(data),
    .i_last(last), .o_we(we), .o_wdata(wdata), .i_full(full), .i_wcnt(wcnt),
    .o_pkt_done(pkt), .o_ovf_err(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A group is a queue of staged words; phase 0 = collecting, 1 = waiting
  // for FIFO room, 2 = draining the group one word per non-full cycle.
  logic [DW-1:0] m_q[$];
  int            m_phase, m_sent, m_idle;
  bit            m_last;
  logic          m_we, m_pkt, m_ovf;
  logic [DW-1:0] m_wdata;
  bit            chk_en = 1'b0;

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      m_q.delete();
      m_phase = 0; m_sent = 0; m_idle = 0; m_last = 1'b0;
      m_we = 1'b0; m_pkt = 1'b0; m_ovf = 1'b0; m_wdata = '0;
    end else begin
      bit rdy;
      rdy  = (m_phase == 0) && (m_q.size() < BL);
      m_we = 1'b0;
      m_pkt = 1'b0;
      if (m_phase == 0) begin
        if (valid && rdy) begin
          m_q.push_back(data);
          m_idle = 0;
          if (last) m_last = 1'b1;
          if (last || m_q.size() == BL) m_phase = 1;
        end else if (m_q.size() == 0) begin
          m_idle = 0;
        end else if (TO != 0 && m_idle == TO - 1) begin
          m_phase = 1;
        end else begin
          m_idle++;
        end
      end else if (m_phase == 1) begin
        if (!full && (((1 << AW) - 1) - int'(wcnt)) >= (m_q.size() + GD)) m_phase = 2;
      end else begin
        if (!full) begin
          m_we    = 1'b1;
          m_wdata = m_q[m_sent];
          m_sent++;
          if (m_sent == m_q.size()) begin
            m_pkt = m_last;
            m_last = 1'b0;
            m_q.delete();
            m_sent = 0; m_idle = 0; m_phase = 0;
          end
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", ready, 32'(!arst && m_phase == 0 && m_q.size() < BL));
      chk("we", we, m_we);
      if (m_we) chk("wdata", wdata, m_wdata);
      chk("pkt_done", pkt, m_pkt);
      chk("ovf_err", ovf, m_ovf);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic l);
    chk("push_ready", ready, 1);
    valid = 1'b1; data = d; last = l;
    tick();
    valid = 1'b0; last = 1'b0;
  endtask

  int nwe;
  int nw_rand;

  initial begin
    arst = 1'b1; valid = 1'b0; data = '0; last = 1'b0; full = 1'b0; wcnt = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_we", we, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_pkt", pkt, 0);
    chk("rst_ovf", ovf, 0);
    chk_en = 1'b1;
    arst = 1'b0;
    tick();
    chk("idle_ready", ready, 1);

    // 1: full burst of four, writes start two edges after the 4th accept
    push(8'h11, 1'b0); push(8'h12, 1'b0); push(8'h13, 1'b0); push(8'h14, 1'b0);
    chk("t1_ready_low", ready, 0);
    tick(); chk("t1_e1_we", we, 0);
    tick(); chk("t1_w0_we", we, 1); chk("t1_w0", wdata, 32'h11);
    tick(); chk("t1_w1", wdata, 32'h12);
    tick(); chk("t1_w2", wdata, 32'h13);
    tick(); chk("t1_w3", wdata, 32'h14); chk("t1_w3_we", we, 1);
    chk("t1_ready_back", ready, 1); chk("t1_pkt", pkt, 0);

    // 2: single-word packet
    push(8'hA0, 1'b1);
    tick(); chk("t2_e1_we", we, 0);
    tick(); chk("t2_we", we, 1); chk("t2_data", wdata, 32'hA0); chk("t2_pkt", pkt, 1);
    tick(); chk("t2_we_end", we, 0); chk("t2_pkt_end", pkt, 0);

    // 3: partial group flushed by the idle timeout
    push(8'h21, 1'b0); push(8'h22, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 15) chk("t3_still_fill", ready, 1);
    end
    chk("t3_flushing", ready, 0);
    tick(); chk("t3_e17_we", we, 0);
    tick(); chk("t3_w0", wdata, 32'h21); chk("t3_w0_we", we, 1);
    tick(); chk("t3_w1", wdata, 32'h22); chk("t3_pkt", pkt, 0);
    tick(); chk("t3_we_end", we, 0);

    // 4: insufficient room stalls until free space reaches count+GUARD
    wcnt = 8'd250;
    push(8'h51, 1'b0); push(8'h52, 1'b0); push(8'h53, 1'b0); push(8'h54, 1'b0);
    nwe = 0;
    repeat (50) begin
      tick();
      nwe += int'(we);
    end
    chk("t4_stall_we", nwe, 0);
    chk("t4_stall_ready", ready, 0);
    wcnt = 8'd247;
    tick(); chk("t4_e1_we", we, 0);
    tick(); chk("t4_w0", wdata, 32'h51); chk("t4_w0_we", we, 1);
    tick(); chk("t4_w1", wdata, 32'h52);
    tick(); chk("t4_w2", wdata, 32'h53);
    tick(); chk("t4_w3", wdata, 32'h54);
    wcnt = 8'd0;

    // 5: full mid-burst pauses without skip or duplicate, sets sticky error
    push(8'h31, 1'b0); push(8'h32, 1'b0); push(8'h33, 1'b0); push(8'h34, 1'b0);
    tick();
    tick(); chk("t5_w0", wdata, 32'h31);
    tick(); chk("t5_w1", wdata, 32'h32);
    full = 1'b1;
    tick(); chk("t5_p0_we", we, 0); chk("t5_ovf", ovf, 1);
    tick(); chk("t5_p1_we", we, 0);
    tick(); chk("t5_p2_we", we, 0);
    full = 1'b0;
    tick(); chk("t5_w2_we", we, 1); chk("t5_w2", wdata, 32'h33);
    tick(); chk("t5_w3", wdata, 32'h34);
    tick(); chk("t5_ovf_sticky", ovf, 1); chk("t5_we_end", we, 0);

    // 6: reset mid-burst aborts the burst immediately
    push(8'h41, 1'b0); push(8'h42, 1'b0); push(8'h43, 1'b0); push(8'h44, 1'b0);
    tick();
    tick(); chk("t6_w0", wdata, 32'h41);
    tick(); chk("t6_w1", wdata, 32'h42);
    #2 arst = 1'b1;
    #1;
    chk("t6_async_we", we, 0);
    chk("t6_async_ready", ready, 0);
    chk("t6_ovf_cleared", ovf, 0);
    tick(); tick();
    arst = 1'b0;
    tick();
    chk("t6_ready_after", ready, 1);
    nwe = 0;
    repeat (10) begin
      tick();
      nwe += int'(we);
    end
    chk("t6_no_resume", nwe, 0);

    // Randomized traffic against the model
    nw_rand = 0;
    repeat (1500) begin
      valid = 1'($urandom_range(0, 1));
      data  = 8'($urandom);
      last  = ($urandom_range(0, 7) == 0);
      full  = ($urandom_range(0, 15) == 0);
      wcnt  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom_range(0, 200));
      tick();
      nw_rand += int'(we);
    end
    valid = 1'b0; last = 1'b0; full = 1'b0; wcnt = '0;
    repeat (40) tick();
    chk("rand_writes_seen", 32'(nw_rand > 0), 1);
    chk("drain_ready", ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
